vend_mode_sequencer: RTL and testbench
======================================

Name: vend_mode_sequencer

Overview:
- Central controller for the vending machine datapath.
- Captures the three mode requests (customer purchase, owner money withdrawal, owner restock) as edge-triggered pending jobs and arbitrates between them.
- Sequences one job at a time through stock/price read, evaluate and write-back against the stock RAM and bank register.
- Publishes a status code for the seven-segment display encoder in head_module.

Parameters:
- MAX_STOCK, 15: saturation ceiling for a product's stock count (at most 15).
- BANK_W, 8: width of the bank balance and payout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- costumer_mode  in  1  customer purchase request, level; rising edge creates a job
- owner_money_mode  in  1  owner withdrawal request, level; rising edge creates a job
- owner_supply_mode  in  1  owner restock request, level; rising edge creates a job
- product  in  3  product index, 0..7
- costumer_money  in  4  coins inserted
- quantitiy  in  4  restock quantity
- stock_rd_en  out  1  stock/price read strobe
- stock_addr  out  3  product index for read/write
- stock_rd_data  in  4  stock count, valid the cycle after stock_rd_en
- price_rd_data  in  4  product price, valid the cycle after stock_rd_en
- stock_wr_en  out  1  stock write strobe
- stock_wr_data  out  4  new stock count
- bank_rd_data  in  BANK_W  current bank balance, combinational
- bank_wr_en  out  1  bank write strobe
- bank_wr_data  out  BANK_W  new bank balance
- change  out  4  change returned by the last successful vend
- payout  out  BANK_W  amount released by the last withdrawal
- disp_code  out  3  status code for the display encoder
- done  out  1  one-cycle pulse at job completion
- busy  out  1  high outside IDLE
- overrun  out  1  sticky; set when an edge arrives for an already-pending requester

Behaviour:
- Reset (async, rst_n=0): state IDLE; all pending flags, edge registers, operand latches and outputs = 0. An in-flight job is abandoned and no write completes.
- Edge capture: req & ~req_q at a clk edge sets that requester's pending flag and latches its operands on the same edge.
  - customer: product, costumer_money
  - supply: product, quantitiy
  - money: none
- Edge while the same requester's flag is already set: operands are not updated, overrun <= 1 (cleared only by reset).
- Arbitration, in IDLE only: fixed priority owner_supply > owner_money > costumer. The grant clears the winner's pending flag in the same cycle, so a new edge from that requester during service is queued.
- FSM states and outputs. Outputs are registered and asserted exactly during the named state.
  - IDLE:
    - grant supply/customer -> READ
    - grant money -> WRITE
    - no pending -> stay
  - READ: stock_rd_en=1, stock_addr=latched product -> EVAL.
  - EVAL: samples stock_rd_data and price_rd_data.
    - customer, evaluated in priority order:
      - stock==0 -> code SOLD_OUT, go REPORT
      - money<price -> NO_FUNDS, go REPORT
      - bank+price > 2^BANK_W-1 -> BANK_FULL, go REPORT
      - else -> WRITE
    - supply -> WRITE.
  - WRITE:
    - customer: stock_wr_data=stock-1, bank_wr_data=bank+price, both strobes high; change<=money-price; code VEND_OK.
    - supply: stock_wr_data=min(stock+qty, MAX_STOCK) using a 5-bit sum; code RESTOCK_OK, or RESTOCK_CLIP if the sum exceeded MAX_STOCK.
    - money: payout<=bank_rd_data, bank_wr_data=0, bank_wr_en=1; code PAYOUT (also when the balance is 0).
    - -> REPORT
  - REPORT: done=1, disp_code<=code -> IDLE.
- disp_code holds its value until the next REPORT.
- disp_code values: 0 IDLE, 1 VEND_OK, 2 SOLD_OUT, 3 NO_FUNDS, 4 RESTOCK_OK, 5 RESTOCK_CLIP, 6 PAYOUT, 7 BANK_FULL.
- Latency from edge-capture cycle C:
  - customer/supply: READ at C+1, EVAL C+2, WRITE C+3, done C+4; reject paths give done at C+3.
  - money: WRITE C+1, done C+2.
- Back-to-back: after REPORT the FSM returns to IDLE for one cycle before the next grant.
- change and payout are unchanged on reject paths.

Optional Feature:
- Macro VEND_ROUND_ROBIN_EN.
  - Defined: round-robin arbitration; the last-granted requester becomes lowest priority. The pointer resets to customer, so the initial order is supply > money > customer.
  - Undefined: fixed priority as above.

Test Plan:
- Stock[2]=4, price=5; costumer_mode pulse with product=2, money=12 -> stock write 3, bank 0->5, change=7, disp_code=1, done 4 cycles after capture.
- Stock[0]=14; owner_supply_mode with product=0, quantitiy=2 -> stock_wr_data=15, disp_code=5; repeat with stock 4, qty 2 -> 6, disp_code=4.
- Bank=5; owner_money_mode pulse -> payout=5, bank_wr_data=0, disp_code=6, done 2 cycles after capture.
- Stock 0 -> SOLD_OUT; money 3 vs price 5 -> NO_FUNDS; bank=253, price 5 -> BANK_FULL. No write strobes and change unchanged in every case.
- All three modes rise in the same cycle -> service order supply, money, customer; with VEND_ROUND_ROBIN_EN, repeat the triple -> order rotates. Second costumer_mode edge while pending -> overrun=1.
- rst_n low during WRITE -> strobes drop immediately, all outputs 0, pending flags cleared; no done pulse.

Source files
------------

// File: rtl/vend_mode_sequencer.sv
// Vending machine mode sequencer: captures purchase/withdraw/restock requests and runs one job at a time
// through stock/price read, evaluate and write-back. Optional macro VEND_ROUND_ROBIN_EN selects round-robin arbitration.
module vend_mode_sequencer #(
    parameter int unsigned MAX_STOCK = 15,
    parameter int unsigned BANK_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              costumer_mode,
    input  logic              owner_money_mode,
    input  logic              owner_supply_mode,
    input  logic [2:0]        product,
    input  logic [3:0]        costumer_money,
    input  logic [3:0]        quantitiy,
    output logic              stock_rd_en,
    output logic [2:0]        stock_addr,
    input  logic [3:0]        stock_rd_data,
    input  logic [3:0]        price_rd_data,
    output logic              stock_wr_en,
    output logic [3:0]        stock_wr_data,
    input  logic [BANK_W-1:0] bank_rd_data,
    output logic              bank_wr_en,
    output logic [BANK_W-1:0] bank_wr_data,
    output logic [3:0]        change,
    output logic [BANK_W-1:0] payout,
    output logic [2:0]        disp_code,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned W_STK  = 4;
    localparam int unsigned W_SSUM = W_STK + 1;
    localparam int unsigned W_BSUM = BANK_W + 1;

    localparam logic [2:0] C_IDLE         = 3'd0;
    localparam logic [2:0] C_VEND_OK      = 3'd1;
    localparam logic [2:0] C_SOLD_OUT     = 3'd2;
    localparam logic [2:0] C_NO_FUNDS     = 3'd3;
    localparam logic [2:0] C_RESTOCK_OK   = 3'd4;
    localparam logic [2:0] C_RESTOCK_CLIP = 3'd5;
    localparam logic [2:0] C_PAYOUT       = 3'd6;
    localparam logic [2:0] C_BANK_FULL    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_EVAL   = 3'd2,
        S_WRITE  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t r_state;

    // Requester bit order: [2] supply, [1] money, [0] customer
    logic [2:0]       r_req_q;
    logic [2:0]       r_pend;
    logic [2:0]       w_req;
    logic [2:0]       w_edge;
    logic [2:0]       w_grant;
    logic [2:0]       w_hold;
    logic             w_overrun;
    logic             w_take_cust;
    logic             w_take_sup;

    logic [2:0]       r_cust_prod;
    logic [3:0]       r_cust_money;
    logic [2:0]       r_sup_prod;
    logic [3:0]       r_sup_qty;

    logic             r_job_sup;
    logic [3:0]       r_job_opnd;
    logic [2:0]       r_code;

    logic [W_SSUM-1:0] w_sup_sum;
    logic              w_clip;
    logic [W_BSUM-1:0] w_bank_sum;

`ifdef VEND_ROUND_ROBIN_EN
    logic [1:0]       r_last;
`endif

    assign w_req  = {owner_supply_mode, owner_money_mode, costumer_mode};
    assign w_edge = w_req & ~r_req_q;

    // A flag that is being granted this cycle is free to take a new edge
    assign w_hold      = r_pend & ~w_grant;
    assign w_overrun   = |(w_edge & w_hold);
    assign w_take_cust = w_edge[0] & ~w_hold[0];
    assign w_take_sup  = w_edge[2] & ~w_hold[2];

    assign w_sup_sum  = W_SSUM'(stock_rd_data) + W_SSUM'(r_job_opnd);
    assign w_clip     = w_sup_sum > W_SSUM'(MAX_STOCK);
    assign w_bank_sum = W_BSUM'(bank_rd_data) + W_BSUM'(price_rd_data);

    // Arbitration among pending requesters, only while idle
    always_comb begin
        w_grant = 3'b000;
        if (r_state == S_IDLE) begin
`ifdef VEND_ROUND_ROBIN_EN
            unique case (r_last)
                2'd2:    w_grant = r_pend[1] ? 3'b010 : r_pend[0] ? 3'b001 : r_pend[2] ? 3'b100 : 3'b000;
                2'd1:    w_grant = r_pend[0] ? 3'b001 : r_pend[2] ? 3'b100 : r_pend[1] ? 3'b010 : 3'b000;
                default: w_grant = r_pend[2] ? 3'b100 : r_pend[1] ? 3'b010 : r_pend[0] ? 3'b001 : 3'b000;
            endcase
`else
            w_grant = r_pend[2] ? 3'b100 : r_pend[1] ? 3'b010 : r_pend[0] ? 3'b001 : 3'b000;
`endif
        end
    end

    // Edge capture, pending flags and per-requester operand latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q      <= 3'b000;
            r_pend       <= 3'b000;
            overrun      <= 1'b0;
            r_cust_prod  <= '0;
            r_cust_money <= '0;
            r_sup_prod   <= '0;
            r_sup_qty    <= '0;
        end else begin
            r_req_q <= w_req;
            r_pend  <= w_hold | w_edge;
            if (w_overrun) begin
                overrun <= 1'b1;
            end
            if (w_take_cust) begin
                r_cust_prod  <= product;
                r_cust_money <= costumer_money;
            end
            if (w_take_sup) begin
                r_sup_prod <= product;
                r_sup_qty  <= quantitiy;
            end
        end
    end

    // Job sequencer with registered datapath strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_job_sup     <= 1'b0;
            r_job_opnd    <= '0;
            r_code        <= C_IDLE;
            stock_rd_en   <= 1'b0;
            stock_addr    <= '0;
            stock_wr_en   <= 1'b0;
            stock_wr_data <= '0;
            bank_wr_en    <= 1'b0;
            bank_wr_data  <= '0;
            change        <= '0;
            payout        <= '0;
            disp_code     <= C_IDLE;
            done          <= 1'b0;
            busy          <= 1'b0;
`ifdef VEND_ROUND_ROBIN_EN
            r_last        <= 2'd0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant[2]) begin
                        r_state     <= S_READ;
                        busy        <= 1'b1;
                        r_job_sup   <= 1'b1;
                        r_job_opnd  <= r_sup_qty;
                        stock_addr  <= r_sup_prod;
                        stock_rd_en <= 1'b1;
                    end else if (w_grant[1]) begin
                        r_state      <= S_WRITE;
                        busy         <= 1'b1;
                        payout       <= bank_rd_data;
                        bank_wr_data <= '0;
                        bank_wr_en   <= 1'b1;
                        r_code       <= C_PAYOUT;
                    end else if (w_grant[0]) begin
                        r_state     <= S_READ;
                        busy        <= 1'b1;
                        r_job_sup   <= 1'b0;
                        r_job_opnd  <= r_cust_money;
                        stock_addr  <= r_cust_prod;
                        stock_rd_en <= 1'b1;
                    end
                end
                S_READ: begin
                    stock_rd_en <= 1'b0;
                    r_state     <= S_EVAL;
                end
                S_EVAL: begin
                    if (r_job_sup) begin
                        stock_wr_en   <= 1'b1;
                        stock_wr_data <= w_clip ? W_STK'(MAX_STOCK) : w_sup_sum[W_STK-1:0];
                        r_code        <= w_clip ? C_RESTOCK_CLIP : C_RESTOCK_OK;
                        r_state       <= S_WRITE;
                    end else if (stock_rd_data == 4'd0) begin
                        disp_code <= C_SOLD_OUT;
                        done      <= 1'b1;
                        r_state   <= S_REPORT;
                    end else if (r_job_opnd < price_rd_data) begin
                        disp_code <= C_NO_FUNDS;
                        done      <= 1'b1;
                        r_state   <= S_REPORT;
                    end else if (w_bank_sum[BANK_W]) begin
                        disp_code <= C_BANK_FULL;
                        done      <= 1'b1;
                        r_state   <= S_REPORT;
                    end else begin
                        stock_wr_en   <= 1'b1;
                        stock_wr_data <= stock_rd_data - 4'd1;
                        bank_wr_en    <= 1'b1;
                        bank_wr_data  <= w_bank_sum[BANK_W-1:0];
                        change        <= r_job_opnd - price_rd_data;
                        r_code        <= C_VEND_OK;
                        r_state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    stock_wr_en   <= 1'b0;
                    stock_wr_data <= '0;
                    bank_wr_en    <= 1'b0;
                    bank_wr_data  <= '0;
                    disp_code     <= r_code;
                    done          <= 1'b1;
                    r_state       <= S_REPORT;
                end
                S_REPORT: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
`ifdef VEND_ROUND_ROBIN_EN
            if (|w_grant) begin
                r_last <= w_grant[2] ? 2'd2 : (w_grant[1] ? 2'd1 : 2'd0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_vend_mode_sequencer.sv
// Bench for vend_mode_sequencer: stock/price RAM and bank register models around the DUT,
// with a transaction-level reference of vending rules and arbitration order.
module tb_vend_mode_sequencer;

    localparam int unsigned BANK_W    = 8;
    localparam int          MAX_STOCK = 15;
    localparam int          BANK_MAX  = (1 << BANK_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              costumer_mode, owner_money_mode, owner_supply_mode;
    logic [2:0]        product;
    logic [3:0]        costumer_money, quantitiy;
    logic              stock_rd_en, stock_wr_en, bank_wr_en;
    logic [2:0]        stock_addr;
    logic [3:0]        stock_rd_data, price_rd_data, stock_wr_data, change;
    logic [BANK_W-1:0] bank_rd_data, bank_wr_data, payout;
    logic [2:0]        disp_code;
    logic              done, busy, overrun;

    always #5 clk = ~clk;

    vend_mode_sequencer #(.MAX_STOCK(15), .BANK_W(BANK_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .costumer_mode    (costumer_mode),
        .owner_money_mode (owner_money_mode),
        .owner_supply_mode(owner_supply_mode),
        .product          (product),
        .costumer_money   (costumer_money),
        .quantitiy        (quantitiy),
        .stock_rd_en      (stock_rd_en),
        .stock_addr       (stock_addr),
        .stock_rd_data    (stock_rd_data),
        .price_rd_data    (price_rd_data),
        .stock_wr_en      (stock_wr_en),
        .stock_wr_data    (stock_wr_data),
        .bank_rd_data     (bank_rd_data),
        .bank_wr_en       (bank_wr_en),
        .bank_wr_data     (bank_wr_data),
        .change           (change),
        .payout           (payout),
        .disp_code        (disp_code),
        .done             (done),
        .busy             (busy),
        .overrun          (overrun)
    );

    // Datapath surroundings: registered stock/price read, bank register
    logic [3:0]        mem_stock [8];
    logic [3:0]        mem_price [8];
    logic [BANK_W-1:0] mem_bank;
    logic [3:0]        rd_stock, rd_price;
    int                cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stock_rd_en) begin
            rd_stock <= mem_stock[stock_addr];
            rd_price <= mem_price[stock_addr];
        end
        if (stock_wr_en) mem_stock[stock_addr] <= stock_wr_data;
        if (bank_wr_en)  mem_bank <= bank_wr_data;
    end

    assign stock_rd_data = rd_stock;
    assign price_rd_data = rd_price;
    assign bank_rd_data  = mem_bank;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference state and per-job expectations
    int m_stock [8];
    int m_price [8];
    int m_bank, m_change, m_payout;
    int e_code, e_lat, e_stw, e_bkw;
`ifdef VEND_ROUND_ROBIN_EN
    int rr_last = 0;
`endif

    // kind: 0 customer, 1 money, 2 supply
    task automatic model_job(input int kind, input int p, input int opnd);
        e_stw = 0;
        e_bkw = 0;
        if (kind == 0) begin
            e_lat = 3;
            if (m_stock[p] == 0)                       e_code = 2;
            else if (opnd < m_price[p])                e_code = 3;
            else if (m_bank + m_price[p] > BANK_MAX)   e_code = 7;
            else begin
                m_stock[p] = m_stock[p] - 1;
                m_bank     = m_bank + m_price[p];
                m_change   = opnd - m_price[p];
                e_code = 1; e_lat = 4; e_stw = 1; e_bkw = 1;
            end
        end else if (kind == 1) begin
            m_payout = m_bank;
            m_bank   = 0;
            e_code = 6; e_lat = 2; e_bkw = 1;
        end else begin
            e_lat = 4; e_stw = 1;
            if (m_stock[p] + opnd > MAX_STOCK) begin
                m_stock[p] = MAX_STOCK; e_code = 5;
            end else begin
                m_stock[p] = m_stock[p] + opnd; e_code = 4;
            end
        end
    endtask

    function automatic int pick(input logic [2:0] pend);
`ifdef VEND_ROUND_ROBIN_EN
        int c = rr_last;
        for (int s = 0; s < 3; s++) begin
            c = (c + 2) % 3;
            if (pend[c]) begin
                rr_last = c;
                return c;
            end
        end
        return 0;
`else
        if (pend[2]) return 2;
        if (pend[1]) return 1;
        return 0;
`endif
    endfunction

    task automatic set_slot(input int p, input int s, input int pr);
        mem_stock[p] <= 4'(s);
        mem_price[p] <= 4'(pr);
        m_stock[p] = s;
        m_price[p] = pr;
    endtask

    task automatic set_bank(input int v);
        mem_bank <= BANK_W'(v);
        m_bank = v;
    endtask

    // Wait for a done pulse, releasing requests and counting write strobes on the way
    task automatic wait_done(output int got, output int stw, output int bkw);
        got = 0; stw = 0; bkw = 0;
        for (int t = 0; t < 30 && got == 0; t++) begin
            @(negedge clk);
            costumer_mode = 1'b0; owner_money_mode = 1'b0; owner_supply_mode = 1'b0;
            if (stock_wr_en) stw++;
            if (bank_wr_en)  bkw++;
            if (done)        got = 1;
        end
    endtask

    task automatic check_state(input int p);
        check("change", change, m_change);
        check("payout", payout, m_payout);
        check("bank", mem_bank, m_bank);
        check("stock", mem_stock[p], m_stock[p]);
    endtask

    // mask bits: [0] customer, [1] money, [2] supply, all rising together
    task automatic run_jobs(input logic [2:0] mask, input int p, input int money, input int qty);
        int order[$];
        logic [2:0] pend;
        int cap, got, stw, bkw, k;
        pend = mask;
        while (pend != 3'b000) begin
            k = pick(pend);
            order.push_back(k);
            pend[k] = 1'b0;
        end
        @(negedge clk);
        product = 3'(p); costumer_money = 4'(money); quantitiy = 4'(qty);
        costumer_mode = mask[0]; owner_money_mode = mask[1]; owner_supply_mode = mask[2];
        cap = cyc + 1;
        foreach (order[j]) begin
            model_job(order[j], p, (order[j] == 0) ? money : qty);
            wait_done(got, stw, bkw);
            check("done_seen", got, 1);
            if (j == 0) check("latency", cyc - cap, e_lat);
            check("disp_code", disp_code, e_code);
            check("strobes", stw * 2 + bkw, e_stw * 2 + e_bkw);
            check_state(p);
        end
        @(negedge clk);
        check("busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int got, stw, bkw, ndone, m;
        rst_n = 1'b0;
        costumer_mode = 1'b0; owner_money_mode = 1'b0; owner_supply_mode = 1'b0;
        product = '0; costumer_money = '0; quantitiy = '0;
        for (int i = 0; i < 8; i++) set_slot(i, $urandom_range(0, 15), $urandom_range(1, 9));
        set_bank(0);
        m_change = 0; m_payout = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_disp", disp_code, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_en", stock_rd_en, 0);
        rst_n = 1'b1;

        // Vend, restock clip/no-clip, payout
        set_slot(2, 4, 5);
        run_jobs(3'b001, 2, 12, 0);
        set_slot(0, 14, 3);
        run_jobs(3'b100, 0, 0, 2);
        set_slot(0, 4, 3);
        run_jobs(3'b100, 0, 0, 2);
        set_bank(5);
        run_jobs(3'b010, 0, 0, 0);
        run_jobs(3'b010, 0, 0, 0);

        // Reject paths
        set_slot(1, 0, 5);
        run_jobs(3'b001, 1, 9, 0);
        set_slot(1, 4, 5);
        run_jobs(3'b001, 1, 3, 0);
        set_bank(253);
        run_jobs(3'b001, 1, 9, 0);

        // Simultaneous requests, twice
        set_slot(4, 3, 2);
        run_jobs(3'b111, 4, 5, 2);
        run_jobs(3'b111, 4, 5, 2);

        // Second customer edge while the first is still pending
        set_slot(5, 6, 2);
        @(negedge clk);
        product = 3'd5; quantitiy = 4'd1; owner_supply_mode = 1'b1;
        @(negedge clk);
        owner_supply_mode = 1'b0; costumer_mode = 1'b1; costumer_money = 4'd9;
        @(negedge clk);
        costumer_mode = 1'b0;
        @(negedge clk);
        costumer_mode = 1'b1; costumer_money = 4'd2;
        @(negedge clk);
        costumer_mode = 1'b0;
        check("overrun", overrun, 1);
        m = pick(3'b101);
        model_job(m, 5, (m == 0) ? 9 : 1);
        wait_done(got, stw, bkw);
        check("ovr_done1", got, 1);
        check("ovr_code1", disp_code, e_code);
        m = pick(3'b101 & ~(3'b001 << m));
        model_job(m, 5, (m == 0) ? 9 : 1);
        wait_done(got, stw, bkw);
        check("ovr_done2", got, 1);
        check("ovr_code2", disp_code, e_code);
        check_state(5);

        // Randomized jobs
        for (int n = 0; n < 40; n++) begin
            logic [2:0] mask;
            if ($urandom_range(0, 4) == 0) mask = 3'b111;
            else mask = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) set_bank($urandom_range(230, 255));
            if ($urandom_range(0, 5) == 0) set_slot($urandom_range(0, 7), 0, $urandom_range(1, 9));
            run_jobs(mask, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        end

        // Reset in the middle of a write
        set_slot(3, 5, 2);
        set_bank(10);
        @(negedge clk);
        product = 3'd3; costumer_money = 4'd9; costumer_mode = 1'b1;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            @(negedge clk);
            costumer_mode = 1'b0;
            if (stock_wr_en) got = 1;
        end
        check("reach_write", got, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_stock_wr", stock_wr_en, 0);
        check("rst_bank_wr", bank_wr_en, 0);
        check("rst_busy2", busy, 0);
        check("rst_disp2", disp_code, 0);
        check("rst_change", change, 0);
        check("rst_payout", payout, 0);
        check("rst_overrun2", overrun, 0);
        m_change = 0; m_payout = 0;
`ifdef VEND_ROUND_ROBIN_EN
        rr_last = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        check_state(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
